// File: rtl/vx_fetch_ibuf_if.sv
// vx_fetch_ibuf_if: fetch-response input, decode-issue output and per-warp credit bundle.
interface vx_fetch_ibuf_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
);
    logic                   in_valid;
    logic [NW_WIDTH-1:0]    in_wid;
    logic [PC_BITS-1:0]     in_PC;
    logic [NUM_THREADS-1:0] in_tmask;
    logic [INSTR_WIDTH-1:0] in_instr;
    logic [UUID_WIDTH-1:0]  in_uuid;
    logic                   in_ready;
    logic                   out_valid;
    logic [NW_WIDTH-1:0]    out_wid;
    logic [PC_BITS-1:0]     out_PC;
    logic [NUM_THREADS-1:0] out_tmask;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [UUID_WIDTH-1:0]  out_uuid;
    logic                   out_ready;
    logic [NUM_WARPS-1:0]   ibuf_pop;

    modport slave (
        input  in_valid, in_wid, in_PC, in_tmask, in_instr, in_uuid,
        output in_ready,
        output out_valid, out_wid, out_PC, out_tmask, out_instr, out_uuid,
        input  out_ready,
        output ibuf_pop
    );

    modport master (
        output in_valid, in_wid, in_PC, in_tmask, in_instr, in_uuid,
        input  in_ready,
        input  out_valid, out_wid, out_PC, out_tmask, out_instr, out_uuid,
        output out_ready,
        input  ibuf_pop
    );
endinterface

// File: rtl/vx_fetch_ibuf.sv
// vx_fetch_ibuf: per-warp instruction FIFOs with round-robin issue through a registered output stage.
module vx_fetch_ibuf #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int PC_BITS     = 31,
    parameter int INSTR_WIDTH = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int DEPTH       = 4,
    parameter int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input logic            clk,
    input logic            reset,
    vx_fetch_ibuf_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int DW = PC_BITS + NUM_THREADS + INSTR_WIDTH + UUID_WIDTH;

    logic [CW-1:0]       count_q [NUM_WARPS];
    logic [CW-1:0]       count_d [NUM_WARPS];
    logic [PW-1:0]       wr_ptr_q [NUM_WARPS];
    logic [PW-1:0]       wr_ptr_d [NUM_WARPS];
    logic [PW-1:0]       rd_ptr_q [NUM_WARPS];
    logic [PW-1:0]       rd_ptr_d [NUM_WARPS];
    logic [DW-1:0]       mem_q [NUM_WARPS*DEPTH];
    logic [DW-1:0]       mem_d [NUM_WARPS*DEPTH];
    logic [NW_WIDTH-1:0] rr_q, rr_d;
    logic                out_valid_q, out_valid_d;
    logic [NW_WIDTH-1:0] out_wid_q, out_wid_d;
    logic [DW-1:0]       out_data_q, out_data_d;
    logic [NW_WIDTH-1:0] win, idx;
    logic                found, push, deq, in_ready;

    // Space is judged from the registered count; a same-cycle dequeue never frees it early.
    always_comb begin
        in_ready = count_q[bus.in_wid] != CW'(DEPTH);
        push = bus.in_valid && in_ready;
        found = 1'b0;
        win = '0;
        idx = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            idx = NW_WIDTH'((int'(rr_q) + i) % NUM_WARPS);
            if (!found && count_q[idx] != '0) begin
                found = 1'b1;
                win = idx;
            end
        end
        deq = found && (!out_valid_q || bus.out_ready);
        count_d = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d = mem_q;
        if (push) begin
            mem_d[{bus.in_wid, wr_ptr_q[bus.in_wid]}] = {bus.in_PC, bus.in_tmask, bus.in_instr, bus.in_uuid};
            wr_ptr_d[bus.in_wid] = wr_ptr_q[bus.in_wid] + 1'b1;
            count_d[bus.in_wid] = count_d[bus.in_wid] + 1'b1;
        end
        if (deq) begin
            rd_ptr_d[win] = rd_ptr_q[win] + 1'b1;
            count_d[win] = count_d[win] - 1'b1;
        end
        out_valid_d = deq || (out_valid_q && !bus.out_ready);
        out_wid_d = deq ? win : out_wid_q;
        out_data_d = deq ? mem_q[{win, rd_ptr_q[win]}] : out_data_q;
        rr_d = deq ? ((int'(win) == NUM_WARPS - 1) ? '0 : win + 1'b1) : rr_q;
    end

    always_comb begin
        bus.ibuf_pop = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            bus.ibuf_pop[w] = out_valid_q && bus.out_ready && (out_wid_q == NW_WIDTH'(w));
    end

    assign bus.in_ready = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_wid = out_wid_q;
    assign {bus.out_PC, bus.out_tmask, bus.out_instr, bus.out_uuid} = out_data_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '{default: '0};
            wr_ptr_q <= '{default: '0};
            rd_ptr_q <= '{default: '0};
            rr_q <= '0;
            out_valid_q <= 1'b0;
            out_wid_q <= '0;
            out_data_q <= '0;
        end else begin
            assert (!push || count_q[bus.in_wid] != CW'(DEPTH));
            assert (!deq || count_q[win] != '0);
            count_q <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            rr_q <= rr_d;
            out_valid_q <= out_valid_d;
            out_wid_q <= out_wid_d;
            out_data_q <= out_data_d;
        end
    end

    // Storage needs no reset: validity is tracked entirely by the counts and pointers.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_vx_fetch_ibuf.sv
// tb_vx_fetch_ibuf: directed checks of vx_fetch_ibuf with immediate assertions.
module tb_vx_fetch_ibuf;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  wid;
        logic [30:0] pc;
    } sb_t;
    sb_t sb[$];

    always #5 clk = ~clk;

    vx_fetch_ibuf_if bus ();
    vx_fetch_ibuf dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] w, input logic [30:0] pc);
        bus.in_valid = 1'b1;
        bus.in_wid = w;
        bus.in_PC = pc;
        bus.in_tmask = 4'hF;
        bus.in_instr = 32'h13;
        bus.in_uuid = 44'(pc);
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int pushed, pops, cyc, fidx;
        logic stalled;
        logic [1:0] hw;
        logic [30:0] hpc;
        logic [1:0] ew [6];
        logic [30:0] ep [6];
        bus.in_valid = 1'b0;
        bus.in_wid = '0;
        bus.in_PC = '0;
        bus.in_tmask = '0;
        bus.in_instr = '0;
        bus.in_uuid = '0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        chk("rst out_valid", bus.out_valid, 0);
        chk("rst ibuf_pop", bus.ibuf_pop, 0);
        chk("rst out_PC", bus.out_PC, 0);
        chk("rst out_uuid", bus.out_uuid, 0);
        reset = 1'b1;
        tick();
        chk("rst in_ready", bus.in_ready, 1);

        // 1: single push, two-edge latency, one credit pulse
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_wid = 2'd2;
        bus.in_PC = 31'h40;
        bus.in_tmask = 4'b1011;
        bus.in_instr = 32'h13;
        bus.in_uuid = 44'd7;
        tick();
        bus.in_valid = 1'b0;
        chk("t1 no bypass", bus.out_valid, 0);
        tick();
        chk("t1 out_valid", bus.out_valid, 1);
        chk("t1 out_wid", bus.out_wid, 2);
        chk("t1 out_PC", bus.out_PC, 31'h40);
        chk("t1 out_tmask", bus.out_tmask, 4'b1011);
        chk("t1 out_instr", bus.out_instr, 32'h13);
        chk("t1 out_uuid", bus.out_uuid, 7);
        chk("t1 ibuf_pop", bus.ibuf_pop, 4'b0100);
        tick();
        chk("t1 drained", bus.out_valid, 0);
        chk("t1 pop once", bus.ibuf_pop, 0);

        // 2: fill wid1 (one entry staged + four buffered), refuse the extra push
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'd1, 31'(32'h100 + i));
        bus.in_wid = 2'd1;
        #1;
        chk("t2 full in_ready", bus.in_ready, 0);
        bus.in_wid = 2'd0;
        #1;
        chk("t2 other in_ready", bus.in_ready, 1);
        bus.in_wid = 2'd1;
        bus.in_PC = 31'h1FF;
        bus.in_valid = 1'b1;
        #1;
        chk("t2 refuse", bus.in_ready, 0);
        tick();
        bus.in_valid = 1'b0;
        chk("t2 stall valid", bus.out_valid, 1);
        chk("t2 stall PC", bus.out_PC, 31'h100);
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("t2 drain valid", bus.out_valid, 1);
            chk("t2 drain PC", bus.out_PC, 31'(32'h100 + i));
            chk("t2 drain pop", bus.ibuf_pop, 4'b0010);
            tick();
        end
        chk("t2 empty", bus.out_valid, 0);

        // 3: round-robin across warps 0,1,3
        bus.out_ready = 1'b0;
        push(2'd0, 31'h200);
        push(2'd1, 31'h210);
        push(2'd3, 31'h230);
        push(2'd0, 31'h201);
        push(2'd1, 31'h211);
        push(2'd3, 31'h231);
        ew = '{2'd0, 2'd1, 2'd3, 2'd0, 2'd1, 2'd3};
        ep = '{31'h200, 31'h210, 31'h230, 31'h201, 31'h211, 31'h231};
        bus.out_ready = 1'b1;
        #1;
        for (int i = 0; i < 6; i++) begin
            chk("t3 valid", bus.out_valid, 1);
            chk("t3 wid", bus.out_wid, ew[i]);
            chk("t3 PC", bus.out_PC, ep[i]);
            tick();
        end
        chk("t3 empty", bus.out_valid, 0);

        // 4: random pushes with random backpressure against a scoreboard
        pushed = 0;
        pops = 0;
        cyc = 0;
        stalled = 1'b0;
        hw = '0;
        hpc = '0;
        while ((pushed < 200 || pops < 200) && cyc < 5000) begin
            if (stalled) begin
                chk("t4 hold valid", bus.out_valid, 1);
                chk("t4 hold wid", bus.out_wid, hw);
                chk("t4 hold PC", bus.out_PC, hpc);
            end
            bus.in_valid = (pushed < 200) && ($urandom_range(0, 3) != 0);
            bus.in_wid = 2'($urandom_range(0, 3));
            bus.in_PC = 31'(32'h1000 + cyc);
            bus.in_uuid = 44'(cyc);
            bus.out_ready = (pushed >= 200) || ($urandom_range(0, 1) == 1);
            #1;
            if (bus.out_valid && bus.out_ready) begin
                chk("t4 pop", bus.ibuf_pop, 4'b0001 << bus.out_wid);
                pops++;
                fidx = -1;
                foreach (sb[k]) if (fidx < 0 && sb[k].wid == bus.out_wid) fidx = k;
                if (fidx < 0) chk("t4 unexpected issue", 1, 0);
                else begin
                    chk("t4 order PC", bus.out_PC, sb[fidx].pc);
                    sb.delete(fidx);
                end
            end else chk("t4 idle pop", bus.ibuf_pop, 0);
            stalled = bus.out_valid && !bus.out_ready;
            hw = bus.out_wid;
            hpc = bus.out_PC;
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back('{wid: bus.in_wid, pc: bus.in_PC});
                pushed++;
            end
            tick();
            cyc++;
        end
        bus.in_valid = 1'b0;
        chk("t4 pushes", pushed, 200);
        chk("t4 pop pulses", pops, 200);
        chk("t4 scoreboard empty", sb.size(), 0);
        chk("t4 idle", bus.out_valid, 0);

        // 5: full wid0 being dequeued still refuses a push that cycle
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(2'd0, 31'(32'h300 + i));
        bus.in_wid = 2'd0;
        bus.in_PC = 31'h305;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t5 refuse while deq", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        #1;
        chk("t5 accept next", bus.in_ready, 1);
        tick();
        bus.in_valid = 1'b0;
        #1;
        chk("t5 full again", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        #1;
        for (int i = 1; i < 6; i++) begin
            chk("t5 drain PC", bus.out_PC, 31'(32'h300 + i));
            chk("t5 drain valid", bus.out_valid, 1);
            tick();
        end
        chk("t5 empty", bus.out_valid, 0);

        // 6: asynchronous reset discards staged and buffered entries
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'd2, 31'(32'h500 + i));
        bus.out_ready = 1'b1;
        #1;
        chk("t6 pre pop", bus.ibuf_pop, 4'b0100);
        reset = 1'b0;
        #1;
        chk("t6 rst valid", bus.out_valid, 0);
        chk("t6 rst pop", bus.ibuf_pop, 0);
        chk("t6 rst PC", bus.out_PC, 0);
        tick();
        reset = 1'b1;
        for (int w = 0; w < 4; w++) begin
            bus.in_wid = 2'(w);
            #1;
            chk("t6 in_ready", bus.in_ready, 1);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6 no stale", bus.out_valid, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
